// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
// Module      : branch_predictor
// Description : Fetch-side dynamic branch predictor. A direct-mapped BTB with
//               per-entry 2-bit saturating counters predicts taken/target for
//               the fetch PC. The branch in Execute is resolved against the
//               prediction carried down the pipe. A wrong prediction raises
//               mispredict and supplies the redirect PC.
// Ports       :
//   i_clk          clock, all state updates on the rising edge
//   i_rst          synchronous active-low reset
//   pc_F           fetch PC (word aligned)
//   pred_taken_F   prediction: redirect fetch to pred_target_F
//   pred_target_F  predicted target (meaningful only when pred_taken_F=1)
//   valid_E        E-stage slot holds a real instruction
//   is_br_E        E instruction is a branch/jal/jalr
//   br_sel         actual taken outcome in E
//   pc_E           PC of the E instruction
//   target_E       actual target computed in E
//   pred_taken_E   pred_taken_F piped to E
//   pred_target_E  pred_target_F piped to E
//   mispredict     to hazard unit: flush D/E, redirect fetch
//   redirect_pc    correct next PC when mispredict=1
//   br_count       resolved branches since reset (saturating)
//   mispred_count  mispredictions since reset (saturating)
// Revision    : 1.0 - initial release
// ============================================================================
module branch_predictor #(
  parameter int IDX_W = 5,
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [XLEN-1:0]  pc_F,
  output logic             pred_taken_F,
  output logic [XLEN-1:0]  pred_target_F,
  input  logic             valid_E,
  input  logic             is_br_E,
  input  logic             br_sel,
  input  logic [XLEN-1:0]  pc_E,
  input  logic [XLEN-1:0]  target_E,
  input  logic             pred_taken_E,
  input  logic [XLEN-1:0]  pred_target_E,
  output logic             mispredict,
  output logic [XLEN-1:0]  redirect_pc,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] mispred_count
);

  localparam int ENTRIES = 2 ** IDX_W;
  localparam int TAG_W   = XLEN - IDX_W - 2;

  // --------------------------------------------------------------------------
  // Table storage
  // --------------------------------------------------------------------------
  logic             valid_tbl  [ENTRIES];
  logic [1:0]       ctr_tbl    [ENTRIES];
  logic [TAG_W-1:0] tag_tbl    [ENTRIES];
  logic [XLEN-1:0]  target_tbl [ENTRIES];

  // --------------------------------------------------------------------------
  // Fetch-side lookup
  // --------------------------------------------------------------------------
  logic [IDX_W-1:0] idx_f;
  logic [TAG_W-1:0] tag_f;
  logic             hit_f;

  assign idx_f = pc_F[IDX_W+1:2];
  assign tag_f = pc_F[XLEN-1:IDX_W+2];
  assign hit_f = valid_tbl[idx_f] && (tag_tbl[idx_f] == tag_f);

  // Table reads are of the current registered state, so an update to the
  // same index in this cycle is only visible from the next cycle on.
  assign pred_taken_F  = i_rst && hit_f && ctr_tbl[idx_f][1];
  assign pred_target_F = target_tbl[idx_f];

  // --------------------------------------------------------------------------
  // Execute-side resolve
  // --------------------------------------------------------------------------
  logic [IDX_W-1:0] idx_e;
  logic [TAG_W-1:0] tag_e;
  logic             hit_e;
  logic             res;
  logic [1:0]       ctr_cur;
  logic [1:0]       ctr_next;

  assign idx_e   = pc_E[IDX_W+1:2];
  assign tag_e   = pc_E[XLEN-1:IDX_W+2];
  assign hit_e   = valid_tbl[idx_e] && (tag_tbl[idx_e] == tag_e);
  assign res     = i_rst && valid_E;
  assign ctr_cur = ctr_tbl[idx_e];

  // Saturating 2-bit counter step toward the actual outcome.
  always_comb begin
    ctr_next = ctr_cur;
    if (br_sel) begin
      if (ctr_cur != 2'b11) begin
        ctr_next = ctr_cur + 2'b01;
      end
    end else begin
      if (ctr_cur != 2'b00) begin
        ctr_next = ctr_cur - 2'b01;
      end
    end
  end

  always_comb begin
    mispredict  = 1'b0;
    redirect_pc = '0;
    if (i_rst) begin
      redirect_pc = (is_br_E && br_sel) ? target_E : (pc_E + XLEN'(4));
    end
    if (res) begin
      if (is_br_E) begin
        mispredict = (br_sel != pred_taken_E) ||
                     (br_sel && (pred_target_E != target_E));
      end else begin
        // A non-branch predicted taken means fetch hit an aliased entry.
        mispredict = pred_taken_E;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Table update: valid bits and counters carry reset state
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_tbl[i] <= 1'b0;
        ctr_tbl[i]   <= 2'b01;
      end
    end else if (res) begin
      if (is_br_E) begin
        if (hit_e) begin
          ctr_tbl[idx_e] <= ctr_next;
        end else if (br_sel) begin
          // Allocate (or replace) on a taken miss, starting weakly taken.
          valid_tbl[idx_e] <= 1'b1;
          ctr_tbl[idx_e]   <= 2'b10;
        end
      end else if (pred_taken_E) begin
        valid_tbl[idx_e] <= 1'b0;
      end
    end
  end

  // Tag and target storage needs no reset; valid gates its use.
  // Any taken branch writes both: on a hit the tag is unchanged, on a miss
  // this is the allocation.
  always_ff @(posedge i_clk) begin
    if (res && is_br_E && br_sel) begin
      tag_tbl[idx_e]    <= tag_e;
      target_tbl[idx_e] <= target_E;
    end
  end

  // --------------------------------------------------------------------------
  // Saturating performance counters
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      br_count      <= '0;
      mispred_count <= '0;
    end else begin
      if (res && is_br_E && (br_count != '1)) begin
        br_count <= br_count + CNT_W'(1);
      end
      if (mispredict && (mispred_count != '1)) begin
        mispred_count <= mispred_count + CNT_W'(1);
      end
    end
  end

  // Byte-offset bits of word-aligned PCs carry no information.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{pc_F[1:0], pc_E[1:0]};

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_predictor
// Description : Directed self-checking bench for branch_predictor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_predictor;

  logic        i_clk;
  logic        i_rst;
  logic [31:0] pc_F;
  logic        pred_taken_F;
  logic [31:0] pred_target_F;
  logic        valid_E;
  logic        is_br_E;
  logic        br_sel;
  logic [31:0] pc_E;
  logic [31:0] target_E;
  logic        pred_taken_E;
  logic [31:0] pred_target_E;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [31:0] br_count;
  logic [31:0] mispred_count;

  int n_checks = 0;
  int n_errors = 0;

  branch_predictor #(
    .IDX_W(5),
    .XLEN (32),
    .CNT_W(32)
  ) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .pc_F         (pc_F),
    .pred_taken_F (pred_taken_F),
    .pred_target_F(pred_target_F),
    .valid_E      (valid_E),
    .is_br_E      (is_br_E),
    .br_sel       (br_sel),
    .pc_E         (pc_E),
    .target_E     (target_E),
    .pred_taken_E (pred_taken_E),
    .pred_target_E(pred_target_E),
    .mispredict   (mispredict),
    .redirect_pc  (redirect_pc),
    .br_count     (br_count),
    .mispred_count(mispred_count)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; inputs change 1 time unit after the edge.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive_e(input logic v, input logic br, input logic sel,
                         input logic [31:0] pc, input logic [31:0] tgt,
                         input logic pt, input logic [31:0] ptg);
    valid_E       = v;
    is_br_E       = br;
    br_sel        = sel;
    pc_E          = pc;
    target_E      = tgt;
    pred_taken_E  = pt;
    pred_target_E = ptg;
    #2;
  endtask

  task automatic idle_e();
    drive_e(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic check_counts(input string tag, input logic [31:0] br, input logic [31:0] mp);
    check_val({tag, "_br_count"}, br_count, br);
    check_val({tag, "_mispred_count"}, mispred_count, mp);
  endtask

  initial begin
    // ---------------- 1: reset with active mismatching E inputs -----------
    i_rst = 1'b0;
    pc_F  = 32'h100;
    drive_e(1'b1, 1'b1, 1'b1, 32'h100, 32'h80, 1'b0, 32'h0);
    tick();
    #2;
    check_val("rst_pred_taken", {31'b0, pred_taken_F}, 32'd0);
    check_val("rst_mispredict", {31'b0, mispredict}, 32'd0);
    check_val("rst_redirect", redirect_pc, 32'h0);
    check_counts("rst", 32'd0, 32'd0);
    tick();
    i_rst = 1'b1;
    idle_e();
    check_val("post_rst_pred_taken", {31'b0, pred_taken_F}, 32'd0);
    check_counts("post_rst", 32'd0, 32'd0);

    // ---------------- 2: taken branch, miss -> allocate -------------------
    drive_e(1'b1, 1'b1, 1'b1, 32'h100, 32'h80, 1'b0, 32'h0);
    check_val("s2_mispredict", {31'b0, mispredict}, 32'd1);
    check_val("s2_redirect", redirect_pc, 32'h80);
    check_val("s2_no_bypass", {31'b0, pred_taken_F}, 32'd0);
    tick();
    idle_e();
    check_val("s2_pred_taken", {31'b0, pred_taken_F}, 32'd1);
    check_val("s2_pred_target", pred_target_F, 32'h80);
    check_counts("s2", 32'd1, 32'd1);

    // ---------------- 3: not taken twice, then hold at 00 -----------------
    drive_e(1'b1, 1'b1, 1'b0, 32'h100, 32'h80, 1'b1, 32'h80);
    check_val("s3a_mispredict", {31'b0, mispredict}, 32'd1);
    check_val("s3a_redirect", redirect_pc, 32'h104);
    tick();
    idle_e();
    check_val("s3a_pred_taken", {31'b0, pred_taken_F}, 32'd0);
    drive_e(1'b1, 1'b1, 1'b0, 32'h100, 32'h80, 1'b0, 32'h80);
    check_val("s3b_mispredict", {31'b0, mispredict}, 32'd0);
    tick();
    idle_e();
    check_val("s3b_pred_taken", {31'b0, pred_taken_F}, 32'd0);
    check_counts("s3b", 32'd3, 32'd2);
    drive_e(1'b1, 1'b1, 1'b0, 32'h100, 32'h80, 1'b0, 32'h80);
    tick();
    idle_e();
    check_val("s3c_sat00_pred", {31'b0, pred_taken_F}, 32'd0);

    // ---------------- 4: squashed slot never trains ------------------------
    drive_e(1'b0, 1'b1, 1'b1, 32'h100, 32'h200, 1'b0, 32'h0);
    check_val("s4_mispredict", {31'b0, mispredict}, 32'd0);
    tick();
    idle_e();
    check_val("s4_pred_taken", {31'b0, pred_taken_F}, 32'd0);
    check_counts("s4", 32'd4, 32'd2);

    // ---------------- counter climb and target update ----------------------
    drive_e(1'b1, 1'b1, 1'b1, 32'h100, 32'h90, 1'b0, 32'h0);   // 00->01
    tick();
    idle_e();
    check_val("up1_pred_taken", {31'b0, pred_taken_F}, 32'd0);
    drive_e(1'b1, 1'b1, 1'b1, 32'h100, 32'h90, 1'b0, 32'h0);   // 01->10
    tick();
    idle_e();
    check_val("up2_pred_taken", {31'b0, pred_taken_F}, 32'd1);
    check_val("up2_pred_target", pred_target_F, 32'h90);
    check_counts("up2", 32'd6, 32'd4);

    // Direction right, target wrong.
    drive_e(1'b1, 1'b1, 1'b1, 32'h100, 32'hA0, 1'b1, 32'h90); // 10->11
    check_val("tgt_mispredict", {31'b0, mispredict}, 32'd1);
    check_val("tgt_redirect", redirect_pc, 32'hA0);
    tick();
    idle_e();
    check_val("tgt_pred_target", pred_target_F, 32'hA0);

    // Fully correct prediction, counter holds at 11.
    drive_e(1'b1, 1'b1, 1'b1, 32'h100, 32'hA0, 1'b1, 32'hA0);
    check_val("ok_mispredict", {31'b0, mispredict}, 32'd0);
    tick();
    drive_e(1'b1, 1'b1, 1'b0, 32'h100, 32'hA0, 1'b1, 32'hA0); // 11->10
    tick();
    idle_e();
    check_val("dn1_pred_taken", {31'b0, pred_taken_F}, 32'd1);
    drive_e(1'b1, 1'b1, 1'b0, 32'h100, 32'hA0, 1'b1, 32'hA0); // 10->01
    tick();
    idle_e();
    check_val("dn2_pred_taken", {31'b0, pred_taken_F}, 32'd0);
    check_counts("dn2", 32'd10, 32'd7);

    // Retrain to weakly taken.
    drive_e(1'b1, 1'b1, 1'b1, 32'h100, 32'h80, 1'b0, 32'h0);  // 01->10
    tick();
    idle_e();
    check_val("rt_pred_taken", {31'b0, pred_taken_F}, 32'd1);
    check_val("rt_pred_target", pred_target_F, 32'h80);

    // ---------------- 5: non-branch alias hit invalidates -----------------
    drive_e(1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 1'b1, 32'h80);
    check_val("s5_mispredict", {31'b0, mispredict}, 32'd1);
    check_val("s5_redirect", redirect_pc, 32'h104);
    tick();
    idle_e();
    check_val("s5_pred_taken", {31'b0, pred_taken_F}, 32'd0);
    check_counts("s5", 32'd11, 32'd9);
    drive_e(1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 1'b0, 32'h0);
    check_val("s5_plain_mispredict", {31'b0, mispredict}, 32'd0);
    tick();

    // ---------------- 6: alias tag, wrap, mid-run reset -------------------
    drive_e(1'b1, 1'b1, 1'b1, 32'h100, 32'h80, 1'b0, 32'h0);
    tick();
    idle_e();
    check_counts("s6", 32'd12, 32'd10);
    pc_F = 32'h180;
    #1;
    check_val("s6_alias_pred", {31'b0, pred_taken_F}, 32'd0);
    pc_F = 32'h100;
    #1;
    check_val("s6_own_pred", {31'b0, pred_taken_F}, 32'd1);

    drive_e(1'b1, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0, 1'b1, 32'h40);
    check_val("wrap_mispredict", {31'b0, mispredict}, 32'd1);
    check_val("wrap_redirect", redirect_pc, 32'h0);
    tick();
    idle_e();
    check_val("wrap_own_pred", {31'b0, pred_taken_F}, 32'd1);
    check_counts("wrap", 32'd13, 32'd11);

    i_rst = 1'b0;
    drive_e(1'b1, 1'b1, 1'b1, 32'h100, 32'h300, 1'b0, 32'h0);
    check_val("mrst_mispredict", {31'b0, mispredict}, 32'd0);
    check_val("mrst_redirect", redirect_pc, 32'h0);
    check_val("mrst_pred_taken", {31'b0, pred_taken_F}, 32'd0);
    tick();
    i_rst = 1'b1;
    idle_e();
    check_val("mrst_cleared_pred", {31'b0, pred_taken_F}, 32'd0);
    check_counts("mrst", 32'd0, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
